// File: rtl/bnn_weight_loader.sv
// bnn_weight_loader
// Weight-loading front end for tiny_bnn. While setup is high, CHUNK-bit slices
// are shifted into a shadow register. When the final chunk arrives the whole
// set is copied to the weight bank in one edge, so the core never sees a
// partially written bank. Short loads and chunks arriving after a commit set
// sticky error flags. Each new load clears both flags.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   setup         in   load-mode strobe
//   data_in       in   CHUNK-bit weight slice, sampled while setup=1
//   weights_out   out  committed weight bank (registered)
//   weights_valid out  a full load has committed since reset
//   load_done     out  one-cycle pulse after the commit edge
//   chunk_count   out  chunks captured in the current load
//   err_short     out  sticky: setup dropped before the load completed
//   err_overflow  out  sticky: chunks presented after commit
module bnn_weight_loader #(
  parameter int CHUNK     = 6,
  parameter int N_WEIGHTS = 48
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              setup,
  input  logic [CHUNK-1:0]                  data_in,
  output logic [N_WEIGHTS-1:0]              weights_out,
  output logic                              weights_valid,
  output logic                              load_done,
  output logic [$clog2(N_WEIGHTS/CHUNK+1)-1:0] chunk_count,
  output logic                              err_short,
  output logic                              err_overflow
);

  localparam int N_CHUNKS = N_WEIGHTS / CHUNK;
  localparam int CW       = $clog2(N_CHUNKS + 1);
  // The shadow holds at most N_CHUNKS-1 chunks. The final chunk goes
  // straight from data_in into the bank on the commit edge.
  localparam int SW       = N_WEIGHTS - CHUNK;

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_CHUNKS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N_CHUNKS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [SW-1:0]        shadow_q, shadow_d;
  logic [N_WEIGHTS-1:0] weights_q, weights_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_short_q, err_short_d;
  logic                 err_ovf_q, err_ovf_d;

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      weights_q   <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= CNT_ZERO;
      err_short_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      weights_q   <= weights_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      err_short_q <= err_short_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  // Next-state logic for the load sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (!setup) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          state_d = LOAD;
        end
      end
      DONE: begin
        if (setup) begin
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and flag updates for each state.
  always_comb begin
    shadow_d    = shadow_q;
    weights_d   = weights_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    err_short_d = err_short_q;
    err_ovf_d   = err_ovf_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          // The truncating cast drops the oldest slice. Every bit of it is
          // replaced before the commit edge.
          shadow_d    = SW'({shadow_q, data_in});
          cnt_d       = CNT_ONE;
          err_short_d = 1'b0;
          err_ovf_d   = 1'b0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      LOAD: begin
        if (!setup) begin
          err_short_d = 1'b1;
          cnt_d       = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          weights_d = {shadow_q, data_in};
          valid_d   = 1'b1;
          done_d    = 1'b1;
          cnt_d     = CNT_FULL;
        end else begin
          shadow_d = SW'({shadow_q, data_in});
          cnt_d    = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        if (setup) begin
          err_ovf_d = 1'b1;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      default: begin
        cnt_d = CNT_ZERO;
      end
    endcase
  end

  assign weights_out   = weights_q;
  assign weights_valid = valid_q;
  assign load_done     = done_q;
  assign chunk_count   = cnt_q;
  assign err_short     = err_short_q;
  assign err_overflow  = err_ovf_q;

endmodule
